// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end sequencer.
package calc_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_GET_A   = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_SHOW    = 3'd4
    } state_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for an already-synchronised button level.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_i;
    end

    assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Captures A, B and opcode on enter presses, waits for the ALU to settle,
// then registers the result for display.
//
//   state     | meaning
//   GET_A     | waiting for operand A press
//   GET_B     | waiting for operand B press
//   GET_OP    | waiting for opcode press; loads settle counter
//   SETTLE    | operands driven, counting down, presses ignored
//   SHOW      | result valid; next press captures a new A
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       enter,
    input  logic       clear,
    input  logic [7:0] alu_result,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [2:0] op_code,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic [2:0] state_o
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       op_a_q, op_b_q, result_q;
    logic [2:0]       op_code_q;
    logic             valid_q, valid_d;
    logic             enter_pulse;
    logic             ld_a, ld_b, ld_op, ld_res;

    edge_rise u_enter_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (enter),
        .pulse_o (enter_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_GET_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_GET_A;
        end else begin
            case (state_q)
                ST_GET_A:  if (enter_pulse) state_d = ST_GET_B;
                ST_GET_B:  if (enter_pulse) state_d = ST_GET_OP;
                ST_GET_OP: if (enter_pulse) state_d = ST_SETTLE;
                ST_SETTLE: if (cnt_q == '0) state_d = ST_SHOW;
                ST_SHOW:   if (enter_pulse) state_d = ST_GET_B;
                default:   state_d = ST_GET_A;
            endcase
        end
    end

    // Load strobes; clear masks every one of them so registers are retained.
    always_comb begin
        ld_a   = !clear && enter_pulse && (state_q == ST_GET_A || state_q == ST_SHOW);
        ld_b   = !clear && enter_pulse && (state_q == ST_GET_B);
        ld_op  = !clear && enter_pulse && (state_q == ST_GET_OP);
        ld_res = !clear && (state_q == ST_SETTLE) && (cnt_q == '0);
        busy   = (state_q == ST_SETTLE);

        cnt_d = cnt_q;
        if (ld_op)
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        else if (state_q == ST_SETTLE && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);

        valid_d = valid_q;
        if (clear || ld_a) valid_d = 1'b0;
        else if (ld_res)   valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (ld_a)   op_a_q    <= sw;
            if (ld_b)   op_b_q    <= sw;
            if (ld_op)  op_code_q <= sw[2:0];
            if (ld_res) result_q  <= alu_result;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_code      = op_code_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a result scoreboard.
module tb_calc_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] op_a, op_b, result;
    logic [2:0] op_code, state_o;
    logic       result_valid, busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    calc_operand_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .enter        (enter),
        .clear        (clear),
        .alu_result   (alu_result),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_code      (op_code),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Bench-side stand-in for the external unit mux
    always_comb begin
        case (op_code)
            3'd0:    alu_result = op_a & op_b;
            3'd1:    alu_result = op_a | op_b;
            3'd2:    alu_result = op_a ^ op_b;
            3'd3:    alu_result = ~op_a;
            3'd4:    alu_result = op_a + op_b;
            3'd5:    alu_result = op_a - op_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        sw    = v;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    // Counts busy cycles from the negedge after the opcode press; optional
    // extra enter pulse injected mid-settle.
    task automatic wait_settle(input bit poke, output int cnt);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            cnt++;
            if (poke && i == 1) begin sw = 8'hFF; enter = 1'b1; end
            if (poke && i == 2) enter = 1'b0;
            @(negedge clk);
        end
    endtask

    // Scoreboard monitor: compares on each rising result_valid
    initial begin
        logic rv_prev;
        logic [7:0] e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%02h, expected no result", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_result", result, e);
                end
            end
            rv_prev = result_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("rst_state", {5'b0, state_o}, 8'd0);
        chk("rst_op_a", op_a, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", {6'b0, result_valid, busy}, 8'h00);
        rst_n = 1'b1;

        // AND: F0 & 3C
        press(8'hF0);
        chk("and_op_a", op_a, 8'hF0);
        chk("and_state_b", {5'b0, state_o}, 8'd1);
        press(8'h3C);
        chk("and_op_b", op_b, 8'h3C);
        exp_q.push_back(8'h30);
        press(8'h00);
        chk("and_busy", {7'b0, busy}, 8'd1);
        wait_settle(1'b0, c);
        chk("and_busy_len", 8'(c), 8'd4);
        chk("and_valid", {7'b0, result_valid}, 8'd1);
        chk("and_result", result, 8'h30);

        // Held enter in GET_A captures once
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("clr_state", {5'b0, state_o}, 8'd0);
        chk("clr_valid", {7'b0, result_valid}, 8'd0);
        sw = 8'hAA; enter = 1'b1;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        chk("hold_state", {5'b0, state_o}, 8'd1);
        chk("hold_op_a", op_a, 8'hAA);

        // OR with an extra press during SETTLE
        press(8'h0F);
        exp_q.push_back(8'hAF);
        press(8'h01);
        wait_settle(1'b1, c);
        chk("or_busy_len", 8'(c), 8'd4);
        repeat (5) @(negedge clk);
        chk("or_show_hold", {5'b0, state_o}, 8'd4);
        chk("or_result", result, 8'hAF);

        // New press from SHOW starts a new calculation
        press(8'h55);
        chk("show_op_a", op_a, 8'h55);
        chk("show_state", {5'b0, state_o}, 8'd1);
        chk("show_valid_drop", {7'b0, result_valid}, 8'd0);
        chk("show_result_kept", result, 8'hAF);

        // clear + enter in GET_OP
        press(8'h33);
        chk("getop_state", {5'b0, state_o}, 8'd2);
        @(negedge clk); clear = 1'b1; enter = 1'b1; sw = 8'h05;
        @(negedge clk); clear = 1'b0; enter = 1'b0;
        chk("clrop_state", {5'b0, state_o}, 8'd0);
        chk("clrop_op_code", {5'b0, op_code}, 8'd1);
        chk("clrop_busy", {7'b0, busy}, 8'd0);

        // SUB: 10 - 01
        press(8'h10);
        press(8'h01);
        exp_q.push_back(8'h0F);
        press(8'h05);
        wait_settle(1'b0, c);
        chk("sub_busy_len", 8'(c), 8'd4);

        // clear + enter in SHOW: op_a kept
        @(negedge clk); clear = 1'b1; enter = 1'b1; sw = 8'h99;
        @(negedge clk); clear = 1'b0; enter = 1'b0;
        chk("clrshow_state", {5'b0, state_o}, 8'd0);
        chk("clrshow_op_a", op_a, 8'h10);
        chk("clrshow_valid", {7'b0, result_valid}, 8'd0);

        // Async reset mid-SETTLE
        press(8'h12);
        press(8'h34);
        press(8'h04);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", {5'b0, state_o}, 8'd0);
        chk("arst_ops", op_a | op_b, 8'h00);
        chk("arst_op_code", {5'b0, op_code}, 8'd0);
        chk("arst_result", result, 8'h00);
        chk("arst_flags", {6'b0, result_valid, busy}, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("arst_after", {5'b0, state_o}, 8'd0);

        // ADD after reset, then NOT from SHOW
        press(8'h12);
        press(8'h34);
        exp_q.push_back(8'h46);
        press(8'h04);
        wait_settle(1'b0, c);
        chk("add_result", result, 8'h46);
        press(8'h0F);
        press(8'h00);
        exp_q.push_back(8'hF0);
        press(8'h03);
        wait_settle(1'b0, c);
        @(negedge clk);

        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
